usb_data_tx_seq: RTL and testbench
==================================

// Module: usb_data_tx_seq
// PURPOSE
//  Sequences one USB DATAx packet through the shared serial crc16 engine.
//  Buffers a full payload from a byte source, then emits a continuous LSB-first bitstream to the stuffer/NRZI stage.
//  Stream order: PID byte, then payload, then the 16 complemented CRC bits returned by the engine.
//  Drives crc_start/crc_bit/crc_rec and supervises crc_ready/crc_done with a watchdog.
// PARAMETERS
//  PAYLOAD_BYTES  8   payload bytes per packet; must equal crc16 engine data length (64 bits)
//  CRC_BITS       16  CRC bits to collect from the engine
//  TIMEOUT        32  max cycles waiting on crc_ready or crc_done before abort
// PORTS
//  clk         in   1  clock
//  rst_n       in   1  reset, asynchronous, active-low
//  tx_go       in   1  start packet; sampled only in IDLE
//  pid_i       in   4  PID nibble, captured with tx_go
//  pl_data     in   8  payload byte
//  pl_valid    in   1  pl_data valid
//  pl_ready    out  1  byte accepted when pl_valid & pl_ready
//  bit_out     out  1  serial packet bit
//  bit_valid   out  1  bit_out valid; no backpressure
//  pkt_start   out  1  1-cycle pulse with first PID bit
//  pkt_end     out  1  1-cycle pulse on successful completion
//  busy        out  1  high in every state except IDLE
//  err_timeout out  1  sticky error; cleared by next accepted tx_go
//  crc_start   out  1  1-cycle pulse to crc16 engine
//  crc_bit     out  1  data bit to crc16 engine (s_in)
//  crc_rec     out  1  1-cycle acknowledge/flush to crc16 engine
//  crc_out     in   1  serial CRC bit from engine
//  crc_ready   in   1  engine is shifting CRC bits
//  crc_done    in   1  engine finished, awaiting crc_rec
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, counters 0, err_timeout 0; buffer contents don't-care.
//  Reset mid-packet aborts immediately; no crc_rec is issued.
//  IDLE: on tx_go, capture pid_i, clear err_timeout, go to LOAD next cycle.
//  LOAD: pl_ready=1; store bytes into buf[0..PAYLOAD_BYTES-1] in order.
//    Gaps in pl_valid allowed. After the last byte, go to PID next cycle.
//  PID: 8 cycles; bit_out = {~pid,pid}[k], k=0..7; bit_valid=1; crc_bit=0.
//    pkt_start asserts on k=0. crc_start asserts on k=7.
//  DATA: 8*PAYLOAD_BYTES cycles, starting the cycle after crc_start.
//    bit_out = crc_bit = buf[n/8][n%8], byte 0 first; bit_valid=1.
//  WAIT_CRC: bit_valid=0; tmo counts; on crc_ready go to CRC in the same cycle.
//    The first CRC bit is taken that cycle.
//  CRC: while crc_ready, bit_out=crc_out, bit_valid=1, count bits.
//    After CRC_BITS bits, go to WAIT_DONE.
//    crc_ready dropping before CRC_BITS bits go to ABORT.
//  WAIT_DONE: bit_valid=0; tmo counts. On crc_done, crc_rec=1 and pkt_end=1 in that cycle, then IDLE.
//  ABORT: crc_rec=1 for one cycle, err_timeout=1, then IDLE.
//    Entered when tmo reaches TIMEOUT in WAIT_CRC/WAIT_DONE, or on early crc_ready drop.
//  tmo clears on every state change.
//  tx_go outside IDLE is ignored. pl_valid outside LOAD is not accepted (pl_ready=0).
//  Packet is 8+8*PAYLOAD_BYTES+CRC_BITS valid bits (88 default).
//    bit_valid is contiguous within PID+DATA and within CRC.
//  Counter widths are $clog2(max+1); no wrap is reachable in legal operation.
// TESTING
//  T1: pid=4'h3, bytes 00..07.
//    -> PID bits 1,1,0,0,0,0,1,1; crc_start on 8th bit; 64 payload bits LSB-first.
//    -> 16 CRC bits match ~CRC16(0x8005, init FFFF); pkt_end once; 88 valid bits.
//  T2: bytes with 0-3 idle cycles between pl_valid -> all captured in order; PID starts 1 cycle after 8th accept.
//  T3: tx_go pulsed during DATA -> ignored; exactly one packet; busy stays high until pkt_end.
//  T4: engine model never raises crc_ready -> after 32 cycles, crc_rec pulse and err_timeout=1, IDLE.
//    -> Next tx_go clears err_timeout.
//  T5: crc_ready drops after 10 CRC bits -> ABORT, crc_rec pulse, err_timeout=1, no pkt_end.
//  T6: rst_n low during DATA -> all outputs 0 asynchronously.
//    -> After release, a fresh T1 packet is bit-exact.

Source files
------------

// File: rtl/usb_data_tx_seq.sv
// usb_data_tx_seq: buffers one DATAx payload, then streams PID, payload and the
// crc16 engine's CRC bits LSB-first while supervising the engine with a watchdog.
// state     | meaning
// IDLE      | waiting for tx_go
// LOAD      | accepting payload bytes into the buffer
// PID       | shifting {~pid,pid}
// DATA      | shifting payload, feeding the crc engine
// WAIT_CRC  | waiting for crc_ready
// CRC       | forwarding engine CRC bits
// WAIT_DONE | waiting for crc_done
// ABORT     | flush the engine, flag timeout
module usb_data_tx_seq #(
  parameter int PAYLOAD_BYTES = 8,
  parameter int CRC_BITS      = 16,
  parameter int TIMEOUT       = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_go,
  input  logic [3:0] pid_i,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       pkt_start,
  output logic       pkt_end,
  output logic       busy,
  output logic       err_timeout,
  output logic       crc_start,
  output logic       crc_bit,
  output logic       crc_rec,
  input  logic       crc_out,
  input  logic       crc_ready,
  input  logic       crc_done
);

  localparam int IDX_W = $clog2(PAYLOAD_BYTES);
  localparam int CNT_W = $clog2(CRC_BITS + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PID, S_DATA, S_WAIT_CRC, S_CRC, S_WAIT_DONE, S_ABORT
  } state_t;

  state_t           state, state_nx;
  logic [3:0]       pid_r;
  logic [IDX_W-1:0] byte_idx;
  logic [2:0]       bit_idx;
  logic [CNT_W-1:0] crc_cnt;
  logic [TMO_W-1:0] tmo;
  logic [7:0]       pl_buf [PAYLOAD_BYTES];
  logic [7:0]       pid_byte;
  logic [7:0]       cur_byte;
  logic             last_byte;
  logic             tmo_hit;

  assign pid_byte  = {~pid_r, pid_r};
  assign cur_byte  = pl_buf[byte_idx];
  assign last_byte = (byte_idx == IDX_W'(PAYLOAD_BYTES - 1));
  assign tmo_hit   = (tmo == TMO_W'(TIMEOUT - 1));
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_nx  = state;
    pl_ready  = 1'b0;
    bit_out   = 1'b0;
    bit_valid = 1'b0;
    pkt_start = 1'b0;
    pkt_end   = 1'b0;
    crc_start = 1'b0;
    crc_bit   = 1'b0;
    crc_rec   = 1'b0;
    case (state)
      S_IDLE: if (tx_go) state_nx = S_LOAD;
      S_LOAD: begin
        pl_ready = 1'b1;
        if (pl_valid && last_byte) state_nx = S_PID;
      end
      S_PID: begin
        bit_valid = 1'b1;
        bit_out   = pid_byte[bit_idx];
        pkt_start = (bit_idx == 3'd0);
        if (bit_idx == 3'd7) begin
          crc_start = 1'b1;
          state_nx  = S_DATA;
        end
      end
      S_DATA: begin
        bit_valid = 1'b1;
        bit_out   = cur_byte[bit_idx];
        crc_bit   = cur_byte[bit_idx];
        if (last_byte && bit_idx == 3'd7) state_nx = S_WAIT_CRC;
      end
      S_WAIT_CRC: begin
        // the first CRC bit is already on crc_out when crc_ready rises
        if (crc_ready) begin
          bit_valid = 1'b1;
          bit_out   = crc_out;
          state_nx  = S_CRC;
        end else if (tmo_hit) begin
          state_nx = S_ABORT;
        end
      end
      S_CRC: begin
        if (crc_ready) begin
          bit_valid = 1'b1;
          bit_out   = crc_out;
          if (crc_cnt == CNT_W'(CRC_BITS - 1)) state_nx = S_WAIT_DONE;
        end else begin
          state_nx = S_ABORT;
        end
      end
      S_WAIT_DONE: begin
        if (crc_done) begin
          crc_rec  = 1'b1;
          pkt_end  = 1'b1;
          state_nx = S_IDLE;
        end else if (tmo_hit) begin
          state_nx = S_ABORT;
        end
      end
      S_ABORT: begin
        crc_rec  = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pid_r       <= '0;
      byte_idx    <= '0;
      bit_idx     <= '0;
      crc_cnt     <= '0;
      tmo         <= '0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      if (state_nx != state) tmo <= '0;
      else if (state == S_WAIT_CRC || state == S_WAIT_DONE) tmo <= tmo + 1'b1;

      if (state == S_IDLE && tx_go) err_timeout <= 1'b0;
      else if (state_nx == S_ABORT) err_timeout <= 1'b1;

      case (state)
        S_IDLE: begin
          crc_cnt <= '0;
          if (tx_go) begin
            pid_r    <= pid_i;
            byte_idx <= '0;
            bit_idx  <= '0;
          end
        end
        S_LOAD: if (pl_valid) byte_idx <= last_byte ? '0 : byte_idx + 1'b1;
        S_PID: bit_idx <= bit_idx + 1'b1;
        S_DATA: begin
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == 3'd7) byte_idx <= last_byte ? '0 : byte_idx + 1'b1;
        end
        S_WAIT_CRC: if (crc_ready) crc_cnt <= CNT_W'(1);
        S_CRC: if (crc_ready) crc_cnt <= crc_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // payload storage carries no reset; contents only matter after a full LOAD
  always_ff @(posedge clk) begin
    if (state == S_LOAD && pl_valid) pl_buf[byte_idx] <= pl_data;
  end

endmodule

// File: tb/tb_usb_data_tx_seq.sv
// Bench for usb_data_tx_seq: behavioural crc16 engine plus a packet-level
// reference model checked against the DUT every cycle.
module tb_usb_data_tx_seq;
  localparam int PB = 8;
  localparam int CB = 16;
  localparam int TO = 32;
  localparam int NBITS = 8 + 8 * PB + CB;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic tx_go = 1'b0;
  logic [3:0] pid_i = '0;
  logic [7:0] pl_data = '0;
  logic pl_valid = 1'b0;
  logic pl_ready, bit_out, bit_valid, pkt_start, pkt_end, busy, err_timeout;
  logic crc_start, crc_bit, crc_rec;
  logic crc_out = 1'b0;
  logic crc_ready = 1'b0;
  logic crc_done = 1'b0;

  always #5 clk = ~clk;

  usb_data_tx_seq #(.PAYLOAD_BYTES(PB), .CRC_BITS(CB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .tx_go(tx_go), .pid_i(pid_i),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
    .bit_out(bit_out), .bit_valid(bit_valid), .pkt_start(pkt_start),
    .pkt_end(pkt_end), .busy(busy), .err_timeout(err_timeout),
    .crc_start(crc_start), .crc_bit(crc_bit), .crc_rec(crc_rec),
    .crc_out(crc_out), .crc_ready(crc_ready), .crc_done(crc_done)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reflected CRC-16/USB over whole bytes, result already complemented
  function automatic logic [15:0] crc16_usb(input logic [7:0] d [16], input int len);
    logic [15:0] r;
    logic fb;
    r = 16'hFFFF;
    for (int i = 0; i < len; i++)
      for (int j = 0; j < 8; j++) begin
        fb = d[i][j] ^ r[0];
        r = r >> 1;
        if (fb) r = r ^ 16'hA001;
      end
    return ~r;
  endfunction

  // reference model state
  logic mq[$];
  logic cap [128];
  logic [7:0] mbytes [16];
  int vidx = 0, cyc = 0, last_vcyc = 0, acc_cyc = 0, rec_cyc = 0;
  int rec_cnt = 0, end_cnt = 0, nacc = 0;
  bit active = 0, loading = 0, err_exp = 0, was = 0;
  logic m_exp, exp_cb;
  logic [15:0] mcrc;

  // engine model state
  int mode = 0;
  int eph = 0, ecnt = 0, edly = 0, esidx = 0;
  logic edata [64];
  logic [15:0] ecrc;
  logic nx_ready = 1'b0, nx_out = 1'b0, nx_done = 1'b0;
  logic fbk;

  initial forever begin
    @(posedge clk);
    #1;
    crc_ready = nx_ready;
    crc_out   = nx_out;
    crc_done  = nx_done;
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      active = 0; loading = 0; err_exp = 0; vidx = 0;
      mq.delete();
      eph = 0; nx_ready = 1'b0; nx_out = 1'b0; nx_done = 1'b0;
    end else begin
      cyc++;
      chk("busy", busy, active);
      chk("pl_ready", pl_ready, loading);
      chk("err_timeout", err_timeout, err_exp || (crc_rec && !pkt_end));
      chk("pkt_start", pkt_start, bit_valid && vidx == 0);
      chk("crc_start", crc_start, bit_valid && vidx == 7);
      if (bit_valid) begin
        chk("bit_avail", mq.size() != 0, 1);
        m_exp = (mq.size() != 0) ? mq.pop_front() : 1'b0;
        chk("bit_out", bit_out, m_exp);
        exp_cb = (vidx >= 8 && vidx < 8 + 8 * PB) ? m_exp : 1'b0;
        chk("crc_bit", crc_bit, exp_cb);
        if (vidx == 0) chk("pid_latency", cyc - acc_cyc, 1);
        else if (vidx != 8 + 8 * PB) chk("contiguous", cyc - last_vcyc, 1);
        if (vidx < 128) cap[vidx] = bit_out;
        vidx++;
        last_vcyc = cyc;
      end else begin
        chk("crc_bit_idle", crc_bit, 0);
      end
      if (pkt_end) end_cnt++;
      if (crc_rec) begin
        rec_cnt++;
        rec_cyc = cyc;
      end

      was = active;
      if (crc_rec) begin
        active = 0;
        if (!pkt_end) err_exp = 1;
      end
      if (!was && tx_go) begin
        active = 1; loading = 1; err_exp = 0; nacc = 0; vidx = 0;
        mq.delete();
        for (int k = 0; k < 8; k++) mq.push_back(k < 4 ? pid_i[k] : ~pid_i[k-4]);
      end else if (loading && pl_valid) begin
        mbytes[nacc] = pl_data;
        for (int k = 0; k < 8; k++) mq.push_back(pl_data[k]);
        nacc++;
        if (nacc == PB) begin
          loading = 0;
          acc_cyc = cyc;
          mcrc = crc16_usb(mbytes, PB);
          for (int k = 0; k < CB; k++) mq.push_back(mcrc[k]);
        end
      end

      // crc16 engine: MSB-first serial form of poly 0x8005
      case (eph)
        0: if (crc_start) begin eph = 1; ecnt = 0; end
        1: begin
          edata[ecnt] = crc_bit;
          ecnt++;
          if (ecnt == 8 * PB) begin
            ecrc = 16'hFFFF;
            for (int k = 0; k < 8 * PB; k++) begin
              fbk = edata[k] ^ ecrc[15];
              ecrc = {ecrc[14:0], 1'b0};
              if (fbk) ecrc = ecrc ^ 16'h8005;
            end
            ecrc = ~ecrc;
            if (mode == 1) eph = 5;
            else begin eph = 2; edly = $urandom_range(0, 3); end
          end
        end
        2: if (edly == 0) begin
             eph = 3; esidx = 0; nx_ready = 1'b1; nx_out = ecrc[15];
           end else edly--;
        3: begin
          esidx++;
          if (mode == 2 && esidx == 10) begin nx_ready = 1'b0; eph = 5; end
          else if (esidx == CB) begin nx_ready = 1'b0; nx_done = 1'b1; eph = 4; end
          else nx_out = ecrc[15-esidx];
        end
        4: if (crc_rec) begin nx_done = 1'b0; eph = 0; end
        5: if (crc_rec) eph = 0;
        default: eph = 0;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] pid, input logic [7:0] b [8], input int gap,
                      input bit go_mid, input int rst_at);
    int r0;
    bit ok, done, aborted;
    r0 = rec_cnt;
    aborted = 0;
    pid_i = pid; tx_go = 1'b1; pl_valid = 1'b1; pl_data = 8'hEE;
    step();
    tx_go = 1'b0; pl_valid = 1'b0;
    chk("err_clear", err_timeout, 0);
    for (int i = 0; i < PB; i++) begin
      pl_valid = 1'b0;
      repeat ($urandom_range(0, gap)) step();
      pl_valid = 1'b1;
      pl_data = b[i];
      ok = 0;
      for (int t = 0; t < 20 && !ok; t++) begin
        @(negedge clk);
        ok = pl_ready;
        step();
      end
      chk("load_accept", ok, 1);
    end
    done = 0;
    for (int t = 0; t < 400 && !done; t++) begin
      pl_valid = 1'($urandom_range(0, 1));
      pl_data = 8'($urandom);
      tx_go = go_mid && (vidx == 40);
      if (rst_at >= 0 && vidx == rst_at) begin
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outs", {bit_out, bit_valid, pkt_start, pkt_end, busy,
                                   err_timeout, crc_start, crc_bit, crc_rec, pl_ready}, 0);
        tx_go = 1'b0; pl_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        aborted = 1;
        done = 1;
      end else begin
        step();
        done = (rec_cnt != r0);
      end
    end
    tx_go = 1'b0; pl_valid = 1'b0;
    step();
    if (aborted) chk("no_rec_on_reset", rec_cnt - r0, 0);
    else chk("pkt_finished", done, 1);
  endtask

  task automatic post_chk(input int md, input int e0);
    if (md == 0) begin
      chk("valid_bits", vidx, NBITS);
      chk("queue_left", mq.size(), 0);
      chk("pkt_end_cnt", end_cnt - e0, 1);
      chk("done_latency", rec_cyc - last_vcyc, 1);
      chk("err_after_ok", err_timeout, 0);
    end else begin
      chk("valid_bits_abort", vidx, md == 1 ? 8 + 8 * PB : 8 + 8 * PB + 10);
      chk("pkt_end_abort", end_cnt - e0, 0);
      chk("abort_latency", rec_cyc - last_vcyc, md == 1 ? TO + 1 : 2);
      chk("err_sticky", err_timeout, 1);
    end
    chk("idle_busy", busy, 0);
  endtask

  logic [7:0] seq_b [8];
  logic [7:0] rnd_b [8];
  logic [7:0] pin_s [16];
  logic [7:0] pb;
  int e0;

  initial begin
    #(1_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) pin_s[i] = (i < 9) ? 8'(8'h31 + i) : 8'h00;
    for (int i = 0; i < 8; i++) seq_b[i] = 8'(i);
    #2 rst_n = 1'b0;
    #1 chk("reset_outs", {bit_out, bit_valid, pkt_start, pkt_end, busy,
                          err_timeout, crc_start, crc_bit, crc_rec, pl_ready}, 0);
    chk("crc_model_pin", crc16_usb(pin_s, 9), 16'hB4C8);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step(); step();

    // T1: pid 3, bytes 00..07
    mode = 0; e0 = end_cnt;
    send(4'h3, seq_b, 0, 0, -1);
    post_chk(0, e0);
    for (int k = 0; k < 8; k++) pb[k] = cap[k];
    chk("t1_pid_bits", pb, 8'hC3);

    // T2: idle gaps between payload bytes
    for (int i = 0; i < 8; i++) rnd_b[i] = 8'($urandom);
    e0 = end_cnt;
    send(4'($urandom), rnd_b, 3, 0, -1);
    post_chk(0, e0);

    // T3: tx_go during DATA ignored
    for (int i = 0; i < 8; i++) rnd_b[i] = 8'($urandom);
    e0 = end_cnt;
    send(4'hB, rnd_b, 1, 1, -1);
    post_chk(0, e0);
    repeat (5) step();
    chk("t3_no_second_pkt", busy, 0);

    // T4: engine never raises crc_ready
    mode = 1; e0 = end_cnt;
    send(4'h5, seq_b, 0, 0, -1);
    post_chk(1, e0);
    mode = 0; e0 = end_cnt;
    send(4'h3, seq_b, 1, 0, -1);
    post_chk(0, e0);

    // T5: crc_ready drops after 10 CRC bits
    mode = 2; e0 = end_cnt;
    for (int i = 0; i < 8; i++) rnd_b[i] = 8'($urandom);
    send(4'hC, rnd_b, 2, 0, -1);
    post_chk(2, e0);

    // T6: reset during DATA, then a fresh T1 packet
    mode = 0;
    send(4'h3, seq_b, 0, 0, 30);
    repeat (3) step();
    e0 = end_cnt;
    send(4'h3, seq_b, 0, 0, -1);
    post_chk(0, e0);
    for (int k = 0; k < 8; k++) pb[k] = cap[k];
    chk("t6_pid_bits", pb, 8'hC3);

    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 8; i++) rnd_b[i] = 8'($urandom);
      e0 = end_cnt;
      send(4'($urandom), rnd_b, 2, 0, -1);
      post_chk(0, e0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
